// File: rtl/weight_update_unit_if.sv
// Delta stream, direct-load, epoch-control and weight-read signals of weight_update_unit.
// The master modport is the driver side; the slave modport is the weight update unit.
interface weight_update_unit_if #(
  parameter int unsigned IDX_W = 2
);
  logic             iDELTA_VALID;
  logic [31:0]      iDELTA;
  logic [IDX_W-1:0] iIDX;
  logic             oDELTA_READY;
  logic             iLOAD;
  logic [IDX_W-1:0] iLOAD_IDX;
  logic [31:0]      iLOAD_DATA;
  logic             iEPOCH_END;
  logic             oEPOCH_DONE;
  logic [IDX_W-1:0] iRD_IDX;
  logic [31:0]      oRD_WEIGHT;
  logic             oBUSY;
  logic [15:0]      oUPD_CNT;
  logic             oERR;

  modport master (
    output iDELTA_VALID, iDELTA, iIDX, iLOAD, iLOAD_IDX, iLOAD_DATA, iEPOCH_END, iRD_IDX,
    input  oDELTA_READY, oEPOCH_DONE, oRD_WEIGHT, oBUSY, oUPD_CNT, oERR
  );

  modport slave (
    input  iDELTA_VALID, iDELTA, iIDX, iLOAD, iLOAD_IDX, iLOAD_DATA, iEPOCH_END, iRD_IDX,
    output oDELTA_READY, oEPOCH_DONE, oRD_WEIGHT, oBUSY, oUPD_CNT, oERR
  );
endinterface

// File: rtl/weight_update_unit.sv
// FP32 weight store committing w[idx] += delta through an ADD_LAT-deep adder pipeline,
// with same-index hazard stalls and epoch drain. Optional write-back clamp: WEIGHT_CLAMP_EN.
module weight_update_unit #(
  parameter int unsigned NUM_W       = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned ADD_LAT     = 7,
  parameter logic [31:0] INIT_WEIGHT = 32'h3f800000,
  parameter logic [31:0] CLAMP_MAG   = 32'h40800000
) (
  input logic                 iCLK,
  input logic                 iRST_N,
  weight_update_unit_if.slave bus
);

  localparam int unsigned DEPTH = 1 << IDX_W;
`ifdef WEIGHT_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } trkEntry_t;

  state_t      state, stateNext;
  logic [31:0] w       [DEPTH];
  logic [31:0] sumPipe [ADD_LAT];
  trkEntry_t   trk     [ADD_LAT];
  logic        armed, hazard, trkAny, deltaReady, accept, idxInRange, loadInRange, commitEn;
  logic [31:0] rawSum, commitData, rdWeight;
  logic [15:0] updCnt;
  logic        err;

  // FP32 add, round-to-nearest-even, subnormal inputs/results flushed to zero
  function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [27:0] mx, my, sum, mask;
    logic [7:0]  d;
    logic [4:0]  lz;
    logic [24:0] rnd;
    logic        sx, sticky, found, rup;
    int          ee;
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else                    begin x = b; y = a; end
    sx = x[31];
    if (x[30:23] == 8'hff) begin
      if ((x[22:0] != 23'd0) || ((y[30:0] == x[30:0]) && (x[31] != y[31]))) return 32'h7fc00000;
      return x;
    end
    if (x[30:23] == 8'd0) return 32'd0;
    mx = {1'b0, 1'b1, x[22:0], 3'b000};
    my = (y[30:23] == 8'd0) ? 28'd0 : {1'b0, 1'b1, y[22:0], 3'b000};
    d  = x[30:23] - y[30:23];
    if (d > 8'd27) begin
      sticky = |my;
      my     = {27'd0, sticky};
    end else begin
      mask   = ~(28'hfffffff << d);
      sticky = |(my & mask);
      my     = (my >> d) | {27'd0, sticky};
    end
    sum = (x[31] == y[31]) ? mx + my : mx - my;
    if (sum == 28'd0) return 32'd0;
    ee = 32'(x[30:23]);
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      ee  = ee + 1;
    end else begin
      found = 1'b0;
      lz    = 5'd0;
      for (int i = 26; i >= 0; i--) begin
        if (!found && sum[i]) begin
          found = 1'b1;
          lz    = 5'(26 - i);
        end
      end
      sum = sum << lz;
      ee  = ee - int'(lz);
    end
    if (ee <= 0) return {sx, 31'd0};
    rup = sum[2] & (sum[1] | sum[0] | sum[3]);
    rnd = {1'b0, sum[26:3]} + 25'(rup);
    if (rnd[24]) begin
      rnd = rnd >> 1;
      ee  = ee + 1;
    end
    if (ee >= 255) return {sx, 8'hff, 23'd0};
    return {sx, 8'(ee), rnd[22:0]};
  endfunction

  // Hazard scan over every tracker stage, committing stage included
  always_comb begin
    hazard = 1'b0;
    trkAny = 1'b0;
    for (int i = 0; i < int'(ADD_LAT); i++) begin
      if (trk[i].valid) begin
        trkAny = 1'b1;
        if (trk[i].idx == bus.iIDX) hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= RUN;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    deltaReady = 1'b0;
    unique case (state)
      RUN: begin
        deltaReady = armed && !bus.iLOAD && !hazard;
        if (bus.iEPOCH_END) stateNext = DRAIN;
      end
      DRAIN:   if (!trkAny) stateNext = DONE;
      DONE:    stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  assign accept      = bus.iDELTA_VALID && deltaReady;
  assign idxInRange  = 32'(bus.iIDX) < NUM_W;
  assign loadInRange = 32'(bus.iLOAD_IDX) < NUM_W;
  assign rawSum      = fpAdd(w[bus.iIDX], bus.iDELTA);
  // A load to the committing index overrides the commit
  assign commitEn    = trk[ADD_LAT-1].valid &&
                       !(bus.iLOAD && loadInRange && (bus.iLOAD_IDX == trk[ADD_LAT-1].idx));
  assign commitData  = (CLAMP_ON && (sumPipe[ADD_LAT-1][30:0] > CLAMP_MAG[30:0])) ?
                       {sumPipe[ADD_LAT-1][31], CLAMP_MAG[30:0]} : sumPipe[ADD_LAT-1];

  // Adder datapath carries no reset; its data only matters alongside a tracker valid
  always_ff @(posedge iCLK) begin
    sumPipe[0] <= rawSum;
    for (int i = 1; i < int'(ADD_LAT); i++) sumPipe[i] <= sumPipe[i-1];
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < int'(DEPTH); i++) w[i] <= INIT_WEIGHT;
      for (int i = 0; i < int'(ADD_LAT); i++) trk[i] <= '0;
      armed    <= 1'b0;
      updCnt   <= 16'd0;
      err      <= 1'b0;
      rdWeight <= INIT_WEIGHT;
    end else begin
      armed        <= 1'b1;
      trk[0].valid <= accept && idxInRange;
      trk[0].idx   <= bus.iIDX;
      for (int i = 1; i < int'(ADD_LAT); i++) trk[i] <= trk[i-1];
      if (commitEn) w[trk[ADD_LAT-1].idx] <= commitData;
      if (bus.iLOAD && loadInRange) w[bus.iLOAD_IDX] <= bus.iLOAD_DATA;
      if (commitEn && (updCnt != 16'hffff)) updCnt <= updCnt + 16'd1;
      if (accept && !idxInRange) err <= 1'b1;
      rdWeight <= w[bus.iRD_IDX];
    end
  end

  assign bus.oDELTA_READY = deltaReady;
  assign bus.oEPOCH_DONE  = (state == DONE);
  assign bus.oRD_WEIGHT   = rdWeight;
  assign bus.oBUSY        = trkAny;
  assign bus.oUPD_CNT     = updCnt;
  assign bus.oERR         = err;

endmodule

// File: tb/tb_weight_update_unit.sv
// Directed bench for weight_update_unit: a NUM_W=4 instance for the datapath and a
// NUM_W=3 instance for the out-of-range index path.
module tb_weight_update_unit;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  weight_update_unit_if #(.IDX_W(2)) bus4 ();
  weight_update_unit_if #(.IDX_W(2)) bus3 ();

  weight_update_unit #(.NUM_W(4), .IDX_W(2)) dut4 (.iCLK(clk), .iRST_N(rstN), .bus(bus4));
  weight_update_unit #(.NUM_W(3), .IDX_W(2)) dut3 (.iCLK(clk), .iRST_N(rstN), .bus(bus3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic        readySeen;
    logic [31:0] expW [4];
    logic [31:0] expClamp;

    bus4.iDELTA_VALID = 1'b0; bus4.iDELTA = '0; bus4.iIDX = '0; bus4.iLOAD = 1'b0;
    bus4.iLOAD_IDX = '0; bus4.iLOAD_DATA = '0; bus4.iEPOCH_END = 1'b0; bus4.iRD_IDX = 2'd2;
    bus3.iDELTA_VALID = 1'b0; bus3.iDELTA = '0; bus3.iIDX = '0; bus3.iLOAD = 1'b0;
    bus3.iLOAD_IDX = '0; bus3.iLOAD_DATA = '0; bus3.iEPOCH_END = 1'b0; bus3.iRD_IDX = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd",    bus4.oRD_WEIGHT, 32'h3f800000);
    check("rst_ready", 32'(bus4.oDELTA_READY), 32'd0);
    check("rst_done",  32'(bus4.oEPOCH_DONE), 32'd0);
    check("rst_busy",  32'(bus4.oBUSY), 32'd0);
    check("rst_cnt",   32'(bus4.oUPD_CNT), 32'd0);
    check("rst_err",   32'(bus4.oERR), 32'd0);
    check("rst_err3",  32'(bus3.oERR), 32'd0);
    rstN = 1'b1;
    step();
    check("ready_after_rst", 32'(bus4.oDELTA_READY), 32'd1);
    check("rd_after_rst",    bus4.oRD_WEIGHT, 32'h3f800000);

    // single delta to idx 0: 1.0 + 0.5
    bus4.iRD_IDX = 2'd0; bus4.iIDX = 2'd0; bus4.iDELTA = 32'h3f000000; bus4.iDELTA_VALID = 1'b1;
    #1;
    check("d0_ready", 32'(bus4.oDELTA_READY), 32'd1);
    step();
    bus4.iDELTA_VALID = 1'b0;
    repeat (6) step();
    check("d0_cnt_pre",  32'(bus4.oUPD_CNT), 32'd0);
    check("d0_busy_pre", 32'(bus4.oBUSY), 32'd1);
    step();
    check("d0_cnt",    32'(bus4.oUPD_CNT), 32'd1);
    check("d0_busy",   32'(bus4.oBUSY), 32'd0);
    check("d0_rd_old", bus4.oRD_WEIGHT, 32'h3f800000);
    step();
    check("d0_rd_new", bus4.oRD_WEIGHT, 32'h3fc00000);

    // same index back to back: second stalls until first commits
    bus4.iRD_IDX = 2'd1; bus4.iIDX = 2'd1; bus4.iDELTA_VALID = 1'b1;
    #1;
    step();
    n = 0;
    while (bus4.oDELTA_READY !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("raw_stall_cycles", 32'(n), 32'd7);
    step();
    bus4.iDELTA_VALID = 1'b0;
    repeat (8) step();
    check("raw_rd",  bus4.oRD_WEIGHT, 32'h40000000);
    check("raw_cnt", 32'(bus4.oUPD_CNT), 32'd3);

    // load collides with commit to idx 3: load wins, no count
    bus4.iIDX = 2'd3; bus4.iDELTA_VALID = 1'b1;
    #1;
    step();
    bus4.iDELTA_VALID = 1'b0; bus4.iIDX = 2'd0;
    repeat (6) step();
    bus4.iLOAD = 1'b1; bus4.iLOAD_IDX = 2'd3; bus4.iLOAD_DATA = 32'hbf800000;
    #1;
    check("load_ready", 32'(bus4.oDELTA_READY), 32'd0);
    step();
    bus4.iLOAD = 1'b0; bus4.iRD_IDX = 2'd3;
    step();
    check("load_rd",  bus4.oRD_WEIGHT, 32'hbf800000);
    check("load_cnt", 32'(bus4.oUPD_CNT), 32'd3);

    // four indices back to back, then drain
    for (int k = 0; k < 4; k++) begin
      bus4.iIDX = 2'(k); bus4.iDELTA_VALID = 1'b1;
      #1;
      check("b2b_ready", 32'(bus4.oDELTA_READY), 32'd1);
      step();
    end
    bus4.iDELTA_VALID = 1'b0; bus4.iIDX = 2'd0; bus4.iEPOCH_END = 1'b1;
    step();
    bus4.iEPOCH_END = 1'b0;
    n = 0;
    readySeen = 1'b0;
    while (bus4.oEPOCH_DONE !== 1'b1 && n < 30) begin
      if (bus4.oDELTA_READY) readySeen = 1'b1;
      step();
      n++;
    end
    check("drain_cycles", 32'(n), 32'd7);
    check("drain_ready",  32'(readySeen), 32'd0);
    step();
    check("done_pulse_end", 32'(bus4.oEPOCH_DONE), 32'd0);
    check("run_ready",      32'(bus4.oDELTA_READY), 32'd1);
    check("b2b_cnt",        32'(bus4.oUPD_CNT), 32'd7);
    expW = '{32'h40000000, 32'h40200000, 32'h3fc00000, 32'hbf000000};
    for (int k = 0; k < 4; k++) begin
      bus4.iRD_IDX = 2'(k);
      step();
      check("b2b_w", bus4.oRD_WEIGHT, expW[k]);
    end

    // drain with empty tracker: RUN -> DRAIN -> DONE
    bus4.iEPOCH_END = 1'b1;
    step();
    bus4.iEPOCH_END = 1'b0;
    check("idle_drain_0", 32'(bus4.oEPOCH_DONE), 32'd0);
    step();
    check("idle_drain_1",  32'(bus4.oEPOCH_DONE), 32'd1);
    check("idle_done_rdy", 32'(bus4.oDELTA_READY), 32'd0);
    step();
    check("idle_drain_2", 32'(bus4.oEPOCH_DONE), 32'd0);

    // 3.5 + 1.0 with and without the clamp
`ifdef WEIGHT_CLAMP_EN
    expClamp = 32'h40800000;
`else
    expClamp = 32'h40900000;
`endif
    bus4.iLOAD = 1'b1; bus4.iLOAD_IDX = 2'd0; bus4.iLOAD_DATA = 32'h40600000;
    step();
    bus4.iLOAD = 1'b0; bus4.iIDX = 2'd0; bus4.iDELTA = 32'h3f800000; bus4.iDELTA_VALID = 1'b1;
    bus4.iRD_IDX = 2'd0;
    #1;
    check("clamp_ready", 32'(bus4.oDELTA_READY), 32'd1);
    step();
    bus4.iDELTA_VALID = 1'b0;
    repeat (8) step();
    check("clamp_rd",  bus4.oRD_WEIGHT, expClamp);
    check("clamp_cnt", 32'(bus4.oUPD_CNT), 32'd8);

    // out-of-range index on the NUM_W=3 instance
    bus3.iIDX = 2'd3; bus3.iDELTA = 32'h3f000000; bus3.iDELTA_VALID = 1'b1;
    #1;
    check("oor_ready", 32'(bus3.oDELTA_READY), 32'd1);
    step();
    bus3.iDELTA_VALID = 1'b0; bus3.iIDX = 2'd0;
    check("oor_err",  32'(bus3.oERR), 32'd1);
    check("oor_busy", 32'(bus3.oBUSY), 32'd0);
    repeat (8) step();
    check("oor_err_sticky", 32'(bus3.oERR), 32'd1);
    check("oor_cnt",        32'(bus3.oUPD_CNT), 32'd0);
    check("inr_err",        32'(bus4.oERR), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
